// File: rtl/tt_out_arbiter.sv
// ---------------------------------------------------------------------------
// tt_out_arbiter
//
// Round-robin arbiter that shares the single registered output datapath
// among NUM_REQ requesters.  Each grant owns the output for HOLD_CYCLES
// cycles.  While a grant is held, the data is frozen, so the pins stay stable.
//
// Optional feature (compile-time macro TT_OUT_ARB_PRIO0_EN):
//   When this macro is defined, requester 0 has strict priority at every
//   arbitration point.  Grants to requester 0 leave the round-robin pointer
//   untouched.  Requesters 1..NUM_REQ-1 rotate among themselves.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   req        in   request vector, bit i = requester i
//   req_data   in   requester i data at [i*DATA_W +: DATA_W]
//   invert_en  in   invert captured data (sampled when arbitrating)
//   gnt        out  one-hot grant, zero when idle
//   out_data   out  registered shared-datapath output
//   out_valid  out  high while a grant window is active
//   busy       out  mirrors out_valid
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; outputs zero; arbitrate whenever req != 0
// HOLD  | grant window active; count down, arbitrate again at count 0
// ---------------------------------------------------------------------------
module tt_out_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      invert_en,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    output logic                      busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [DATA_W-1:0]  data_q, data_d;

    logic [NUM_REQ-1:0] rr_req;
    logic               found;
    logic [PTR_W-1:0]   win;
    int                 idx;

    // Rotating search starting one past the last winner.
    always_comb begin
        rr_req = req;
`ifdef TT_OUT_ARB_PRIO0_EN
        rr_req[0] = 1'b0;
`endif
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && rr_req[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
`ifdef TT_OUT_ARB_PRIO0_EN
        if (req[0]) begin
            found = 1'b1;
            win   = '0;
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        data_d   = data_q;

        if (state_q == HOLD && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else if (found) begin
            // The next grant loads on the same edge that the previous grant ends.
            // Because of this, there is no gap cycle between windows.
            state_d = HOLD;
            gnt_d   = NUM_REQ'(1) << win;
            data_d  = req_data[win*DATA_W +: DATA_W] ^ {DATA_W{invert_en}};
            cnt_d   = CNT_W'(HOLD_CYCLES - 1);
`ifdef TT_OUT_ARB_PRIO0_EN
            if (win != '0) begin
                rr_ptr_d = win;
            end
`else
            rr_ptr_d = win;
`endif
        end else begin
            state_d = IDLE;
            gnt_d   = '0;
            data_d  = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rr_ptr_q <= PTR_W'(NUM_REQ - 1);
            gnt_q    <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            data_q   <= data_d;
        end
    end

    assign gnt       = gnt_q;
    assign out_data  = data_q;
    assign out_valid = |gnt_q;
    assign busy      = out_valid;

endmodule

// File: tb/tb_tt_out_arbiter.sv
module tb_tt_out_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic        invert_en = 1'b0;
    logic [3:0]  gnt;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    tt_out_arbiter #(.NUM_REQ(4), .DATA_W(8), .HOLD_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .invert_en (invert_en),
        .gnt       (gnt),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        invert_en = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        req_data = 32'h44332211;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) begin
                rst = 1'b0;
                req = '0;
            end
            step();
            n_cmp++;
            if ({gnt, out_data, out_valid, busy} !== 14'd0) begin
                n_bad++;
                $display("FAIL reset_idle cycle %0d: gnt=%b data=%h valid=%b busy=%b, required all 0",
                         c, gnt, out_data, out_valid, busy);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        req_data = 32'h00A50000;
        invert_en = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            n_cmp++;
            if (gnt !== 4'b0100 || out_data !== 8'h5A || out_valid !== 1'b1 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL single cycle %0d: gnt=%b data=%h valid=%b busy=%b, required 0100/5a/1/1",
                         c, gnt, out_data, out_valid, busy);
            end
        end
        req = '0;
        step();
        n_cmp++;
        if ({gnt, out_data, out_valid, busy} !== 14'd0) begin
            n_bad++;
            $display("FAIL single_release: gnt=%b data=%h valid=%b, required all 0", gnt, out_data, out_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        logic [7:0] exp_d;
        int w;
        do_reset();
        req = 4'b1111;
        req_data = 32'hD4C3B2A1;
        for (int c = 0; c < 20; c++) begin
            step();
            w = (c / 4) % 4;
            exp_g = 4'b0001 << w;
            exp_d = 8'hA1 + 8'h11 * w[7:0];
            n_cmp++;
            if (gnt !== exp_g || out_data !== exp_d || out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL round_robin cycle %0d: gnt=%b data=%h valid=%b, required %b/%h/1",
                         c, gnt, out_data, out_valid, exp_g, exp_d);
            end
        end
    endtask

    task automatic test_frozen();
        do_reset();
        req = 4'b0010;
        req_data = 32'h00003C00;
        step();
        req_data = 32'h0000FF00;
        invert_en = 1'b1;
        req = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (gnt !== 4'b0010 || out_data !== 8'h3C) begin
                n_bad++;
                $display("FAIL frozen cycle %0d: gnt=%b data=%h, required 0010/3c", c, gnt, out_data);
            end
            step();
        end
        n_cmp++;
        if ({gnt, out_data, out_valid} !== 13'd0) begin
            n_bad++;
            $display("FAIL frozen_end: gnt=%b data=%h valid=%b, required all 0", gnt, out_data, out_valid);
        end
        invert_en = 1'b0;
    endtask

    task automatic test_persistent();
        logic [7:0] exp_d;
        do_reset();
        req = 4'b1000;
        req_data = 32'h11000000;
        for (int c = 0; c < 8; c++) begin
            step();
            if (c == 0) req_data = 32'h22000000;
            exp_d = (c < 4) ? 8'h11 : 8'h22;
            n_cmp++;
            if (gnt !== 4'b1000 || out_data !== exp_d || out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL persistent cycle %0d: gnt=%b data=%h valid=%b, required 1000/%h/1",
                         c, gnt, out_data, out_valid, exp_d);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b1111;
        req_data = 32'h04030201;
        for (int c = 0; c < 10; c++) step();
        n_cmp++;
        if (gnt !== 4'b0100 || out_data !== 8'h03) begin
            n_bad++;
            $display("FAIL reset_mid_pre: gnt=%b data=%h, required 0100/03", gnt, out_data);
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if ({gnt, out_data, out_valid, busy} !== 14'd0) begin
            n_bad++;
            $display("FAIL reset_mid_clear: gnt=%b data=%h valid=%b busy=%b, required all 0",
                     gnt, out_data, out_valid, busy);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (gnt !== 4'b0001 || out_data !== 8'h01 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_resume: gnt=%b data=%h valid=%b, required 0001/01/1",
                     gnt, out_data, out_valid);
        end
    endtask

`ifdef TT_OUT_ARB_PRIO0_EN
    task automatic test_prio0();
        logic [3:0] exp_g [0:15];
        for (int c = 0; c < 4; c++) exp_g[c] = 4'b0010;
        for (int c = 4; c < 12; c++) exp_g[c] = 4'b0001;
        for (int c = 12; c < 16; c++) exp_g[c] = 4'b0100;
        do_reset();
        req = 4'b1110;
        req_data = 32'h04030201;
        for (int c = 0; c < 16; c++) begin
            step();
            if (c == 1) req = 4'b1111;
            if (c == 9) req = 4'b1110;
            n_cmp++;
            if (gnt !== exp_g[c]) begin
                n_bad++;
                $display("FAIL prio0 cycle %0d: gnt=%b, required %b", c, gnt, exp_g[c]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_frozen();
        test_persistent();
        test_reset_mid();
`ifdef TT_OUT_ARB_PRIO0_EN
        test_prio0();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
